// File: rtl/mmio_pkg.sv
// Shared register map and bit positions for the mmio_ctrl window.
package mmio_pkg;

  localparam logic [2:0] REG_KDATA = 3'd0;
  localparam logic [2:0] REG_SDATA = 3'd1;
  localparam logic [2:0] REG_KEDGE = 3'd2;
  localparam logic [2:0] REG_TCNT  = 3'd3;
  localparam logic [2:0] REG_TLIM  = 3'd4;
  localparam logic [2:0] REG_HEX   = 3'd5;
  localparam logic [2:0] REG_LEDR  = 3'd6;
  localparam logic [2:0] REG_TCTRL = 3'd7;

  localparam int TCTRL_EN  = 0;
  localparam int TCTRL_EXP = 1;
  localparam int TCTRL_TIE = 2;

  localparam int KEDGE_MASK_OFS = 8;
  localparam int LEDG_OFS       = 8;

endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchronizer with optional active-low inversion, level output
// and a one-cycle rising-edge pulse.
module key_sync #(
  parameter int W      = 4,
  parameter bit INVERT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync_p1, sync_p2, prev_p3;

  // Inverting ahead of the first flop lets the all-zero reset state mean "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
      prev_p3 <= '0;
    end else begin
      sync_p1 <= INVERT ? ~raw : raw;
      sync_p2 <= sync_p1;
      prev_p3 <= sync_p2;
    end
  end

  assign lvl  = sync_p2;
  assign rise = sync_p2 & ~prev_p3;

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: 8-register MMIO window (keys, switches, HEX, LEDs, interval timer).
// Define MMIO_CTRL_IRQ_EN to add IRQ, the KEDGE mask, TIE and an independent LEDG register.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int               DBITS = 16,
  parameter int               NKEYS = 4,
  parameter int               NSW   = 10,
  parameter int               NLEDR = 10,
  parameter int               NLEDG = 8,
  parameter logic [DBITS-1:0] BASE  = 16'hFFF0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] ADDR,
  input  logic             WE,
  input  logic             RE,
  input  logic [DBITS-1:0] WDATA,
  output logic [DBITS-1:0] RDATA,
  output logic             HIT,
  input  logic [NKEYS-1:0] KEY,
  input  logic [NSW-1:0]   SW,
  output logic [DBITS-1:0] HEXOUT,
  output logic [NLEDR-1:0] LEDR,
  output logic [NLEDG-1:0] LEDG
`ifdef MMIO_CTRL_IRQ_EN
  ,
  output logic             IRQ
`endif
);

  logic [NKEYS-1:0] key_lvl, key_rise, kedge;
  logic [NSW-1:0]   sw_lvl, sw_rise_unused;
  logic [2:0]       sel;
  logic             wr, rd, wrap, t_en, t_exp;
  logic [DBITS-1:0] rd_val, tcnt, tlim, hex_q;
  logic [NLEDR-1:0] ledr_q;
  logic             unused_bits;
`ifdef MMIO_CTRL_IRQ_EN
  logic [NKEYS-1:0] kmask;
  logic             t_tie, irq_q;
  logic [NLEDG-1:0] ledg_q;
`endif

  key_sync #(.W(NKEYS), .INVERT(1'b1)) u_keys (
    .clk(CLK), .rst_n(RESET_N), .raw(KEY), .lvl(key_lvl), .rise(key_rise)
  );

  key_sync #(.W(NSW), .INVERT(1'b0)) u_sw (
    .clk(CLK), .rst_n(RESET_N), .raw(SW), .lvl(sw_lvl), .rise(sw_rise_unused)
  );

  assign HIT         = (ADDR[DBITS-1:4] == BASE[DBITS-1:4]);
  assign sel         = ADDR[3:1];
  assign wr          = HIT && WE;
  assign rd          = HIT && RE;
  assign wrap        = t_en && (tcnt == tlim);
  assign unused_bits = ^{ADDR[0], sw_rise_unused};

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_KDATA: rd_val[NKEYS-1:0] = key_lvl;
      REG_SDATA: rd_val[NSW-1:0]   = sw_lvl;
      REG_KEDGE: begin
        rd_val[NKEYS-1:0] = kedge;
`ifdef MMIO_CTRL_IRQ_EN
        rd_val[KEDGE_MASK_OFS +: NKEYS] = kmask;
`endif
      end
      REG_TCNT:  rd_val = tcnt;
      REG_TLIM:  rd_val = tlim;
      REG_HEX:   rd_val = hex_q;
      REG_LEDR: begin
        rd_val[NLEDR-1:0] = ledr_q;
`ifdef MMIO_CTRL_IRQ_EN
        rd_val[LEDG_OFS +: NLEDG] = rd_val[LEDG_OFS +: NLEDG] | ledg_q;
`endif
      end
      REG_TCTRL: begin
        rd_val[TCTRL_EN]  = t_en;
        rd_val[TCTRL_EXP] = t_exp;
`ifdef MMIO_CTRL_IRQ_EN
        rd_val[TCTRL_TIE] = t_tie;
`endif
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RDATA  <= '0;
      kedge  <= '0;
      tcnt   <= '0;
      tlim   <= '0;
      hex_q  <= '0;
      ledr_q <= '0;
      t_en   <= 1'b0;
      t_exp  <= 1'b0;
`ifdef MMIO_CTRL_IRQ_EN
      kmask  <= '0;
      t_tie  <= 1'b0;
      ledg_q <= '0;
      irq_q  <= 1'b0;
`endif
    end else begin
      // Reads see pre-write state, so a combined RE/WE returns the old value.
      if (rd) RDATA <= rd_val;
      else if (RE) RDATA <= '0;

      // New press edges win over a same-cycle write-1-to-clear.
      if (wr && sel == REG_KEDGE) kedge <= (kedge & ~WDATA[NKEYS-1:0]) | key_rise;
      else kedge <= kedge | key_rise;

      if (wr && sel == REG_TLIM) begin
        tlim <= WDATA;
        tcnt <= '0;
      end else if (wrap) begin
        tcnt <= '0;
      end else if (t_en) begin
        tcnt <= tcnt + 1'b1;
      end

      if (wrap) t_exp <= 1'b1;
      else if (wr && sel == REG_TCTRL && WDATA[TCTRL_EXP]) t_exp <= 1'b0;

      if (wr && sel == REG_TCTRL) begin
        t_en <= WDATA[TCTRL_EN];
`ifdef MMIO_CTRL_IRQ_EN
        t_tie <= WDATA[TCTRL_TIE];
`endif
      end

      if (wr && sel == REG_HEX) hex_q <= WDATA;

      if (wr && sel == REG_LEDR) begin
        ledr_q <= WDATA[NLEDR-1:0];
`ifdef MMIO_CTRL_IRQ_EN
        ledg_q <= WDATA[LEDG_OFS +: NLEDG];
`endif
      end

`ifdef MMIO_CTRL_IRQ_EN
      if (wr && sel == REG_KEDGE) kmask <= WDATA[KEDGE_MASK_OFS +: NKEYS];
      irq_q <= (|(kedge & kmask)) | (t_exp & t_tie);
`endif
    end
  end

  assign HEXOUT = hex_q;
  assign LEDR   = ledr_q;
`ifdef MMIO_CTRL_IRQ_EN
  assign LEDG   = ledg_q;
  assign IRQ    = irq_q;
`else
  assign LEDG   = hex_q[NLEDG-1:0];
`endif

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed scenarios plus randomized bus/key traffic
// compared every cycle against a behavioural model of the register window.
module tb_mmio_ctrl;

  localparam logic [15:0] BASE = 16'hFFF0;
`ifdef MMIO_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] ADDR, WDATA, RDATA, HEXOUT;
  logic        WE, RE, HIT;
  logic [3:0]  KEY;
  logic [9:0]  SW, LEDR;
  logic [7:0]  LEDG;
`ifdef MMIO_CTRL_IRQ_EN
  logic        IRQ;
`endif

  int total = 0;
  int bad   = 0;

  mmio_ctrl #(
    .DBITS(16), .NKEYS(4), .NSW(10), .NLEDR(10), .NLEDG(8), .BASE(BASE)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .WE(WE), .RE(RE), .WDATA(WDATA),
    .RDATA(RDATA), .HIT(HIT), .KEY(KEY), .SW(SW), .HEXOUT(HEXOUT), .LEDR(LEDR),
    .LEDG(LEDG)
`ifdef MMIO_CTRL_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_kh [0:2];   // pressed-key samples, [0] newest
  logic [9:0]  m_sh [0:1];   // switch samples, [0] newest
  logic [3:0]  m_kedge, m_mask;
  logic [15:0] m_cnt, m_lim, m_hex, m_rdata;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic        m_en, m_exp, m_tie, m_irq;

  function automatic logic [15:0] m_read(input logic [2:0] idx);
    logic [15:0] v;
    v = '0;
    case (idx)
      3'd0: v[3:0] = m_kh[1];
      3'd1: v[9:0] = m_sh[1];
      3'd2: begin v[3:0] = m_kedge; v[11:8] = m_mask; end
      3'd3: v = m_cnt;
      3'd4: v = m_lim;
      3'd5: v = m_hex;
      3'd6: begin v[9:0] = m_ledr; v[15:8] = v[15:8] | m_ledg; end
      default: v = {13'b0, m_tie, m_exp, m_en};
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_kh[i] = '0;
    m_sh[0] = '0; m_sh[1] = '0;
    m_kedge = '0; m_mask = '0; m_cnt = '0; m_lim = '0; m_hex = '0; m_rdata = '0;
    m_ledr = '0; m_ledg = '0; m_en = 1'b0; m_exp = 1'b0; m_tie = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic       hit, wr, wrap, en0, irq_n;
    logic [2:0] idx;
    logic [3:0] rise;
    hit = (ADDR[15:4] == BASE[15:4]);
    idx = ADDR[3:1];
    wr  = hit && WE;
    if (hit && RE) m_rdata = m_read(idx);
    else if (RE) m_rdata = '0;
    rise  = m_kh[1] & ~m_kh[2];
    wrap  = m_en && (m_cnt == m_lim);
    en0   = m_en;
    irq_n = (|(m_kedge & m_mask)) || (m_exp && m_tie);
    if (wr) begin
      case (idx)
        3'd2: begin m_kedge = m_kedge & ~WDATA[3:0]; if (IRQ_EN) m_mask = WDATA[11:8]; end
        3'd4: m_lim = WDATA;
        3'd5: m_hex = WDATA;
        3'd6: begin m_ledr = WDATA[9:0]; if (IRQ_EN) m_ledg = WDATA[15:8]; end
        3'd7: begin
          m_en = WDATA[0];
          if (WDATA[1]) m_exp = 1'b0;
          if (IRQ_EN) m_tie = WDATA[2];
        end
        default: ;
      endcase
    end
    m_kedge = m_kedge | rise;
    if (wr && idx == 3'd4) m_cnt = '0;
    else if (wrap) m_cnt = '0;
    else if (en0) m_cnt = m_cnt + 16'd1;
    if (wrap) m_exp = 1'b1;
    m_irq   = irq_n;
    m_kh[2] = m_kh[1]; m_kh[1] = m_kh[0]; m_kh[0] = ~KEY;
    m_sh[1] = m_sh[0]; m_sh[0] = SW;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      check("rdata", RDATA, m_rdata);
      check("hexout", HEXOUT, m_hex);
      check("ledr", LEDR, m_ledr);
      check("ledg", LEDG, IRQ_EN ? m_ledg : m_hex[7:0]);
      check("hit", HIT, (ADDR[15:4] == BASE[15:4]));
`ifdef MMIO_CTRL_IRQ_EN
      check("irq", IRQ, m_irq);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; WDATA = d; WE = 1'b1; RE = 1'b0;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [15:0] d);
    ADDR = a; RE = 1'b1; WE = 1'b0;
    tick();
    RE = 1'b0;
    d = RDATA;
  endtask

  function automatic logic [15:0] ra(input int idx);
    return BASE | 16'(idx * 2);
  endfunction

  initial begin
    logic [15:0] d, a;
    logic [15:0] seq [5];
    logic [2:0]  idx;
    int          r;
    seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    RESET_N = 1'b0; ADDR = '0; WDATA = '0; WE = 1'b0; RE = 1'b0; KEY = 4'hF; SW = '0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd_reg(ra(i), d);
      check($sformatf("reset_reg%0d", i), d, 16'h0000);
    end
    for (int i = 0; i < 8; i++) begin
      ADDR = ra(i); #1;
      check($sformatf("hit_in%0d", i), HIT, 1'b1);
    end
    ADDR = 16'hFFEE; #1; check("hit_ffee", HIT, 1'b0);
    ADDR = 16'hFFE0; #1; check("hit_ffe0", HIT, 1'b0);

    // key1 pressed, then released
    KEY = 4'b1101; SW = 10'h2A5;
    repeat (3) tick();
    rd_reg(ra(0), d); check("kdata_key1", d, 16'h0002);
    rd_reg(ra(2), d); check("kedge_key1", d, 16'h0002);
    rd_reg(ra(1), d); check("sdata", d, 16'h02A5);
    repeat (4) tick();
    KEY = 4'hF;
    repeat (4) tick();
    rd_reg(ra(0), d); check("kdata_rel", d, 16'h0000);
    rd_reg(ra(2), d); check("kedge_sticky", d, 16'h0002);
    wr_reg(ra(2), 16'h0002);
    rd_reg(ra(2), d); check("kedge_w1c", d, 16'h0000);

    // interval timer
    wr_reg(ra(4), 16'd3);
    wr_reg(ra(7), 16'h0001);
    for (int i = 0; i < 5; i++) begin
      rd_reg(ra(3), d);
      check($sformatf("tcnt_seq%0d", i), d, seq[i]);
    end
    rd_reg(ra(7), d); check("tctrl_exp", d, 16'h0003);
    wr_reg(ra(7), 16'h0003);
    rd_reg(ra(7), d); check("tctrl_w1c", d, 16'h0001);
    wr_reg(ra(7), 16'h0000);

    // HEX and LEDs
    wr_reg(ra(5), 16'hBEEF);
    check("hexout_beef", HEXOUT, 16'hBEEF);
`ifndef MMIO_CTRL_IRQ_EN
    check("ledg_mirror", LEDG, 8'hEF);
`endif
    wr_reg(ra(6), 16'hFFFF);
    check("ledr_all", LEDR, 10'h3FF);
    rd_reg(ra(6), d);
`ifdef MMIO_CTRL_IRQ_EN
    check("ledr_read", d, 16'hFFFF);
`else
    check("ledr_read", d, 16'h03FF);
`endif
    rd_reg(16'hFFEE, d); check("miss_read", d, 16'h0000);

    // W1C colliding with a fresh key0 press edge
    KEY = 4'b1110;
    tick(); tick();
    wr_reg(ra(2), 16'h0001);
    rd_reg(ra(2), d); check("kedge_set_wins", d, 16'h0001);
    KEY = 4'hF;
    repeat (3) tick();

    // asynchronous reset mid-count
    wr_reg(ra(5), 16'h1234);
    wr_reg(ra(4), 16'd100);
    wr_reg(ra(7), 16'h0001);
    repeat (5) tick();
    #3 RESET_N = 1'b0;
    #1 check("hexout_async_rst", HEXOUT, 16'h0000);
    check("ledr_async_rst", LEDR, 10'h000);
    tick();
    RESET_N = 1'b1;
    rd_reg(ra(3), d); check("tcnt_after_rst", d, 16'h0000);
    rd_reg(ra(4), d); check("tlim_after_rst", d, 16'h0000);

    // randomized traffic
    repeat (700) begin
      r   = $urandom_range(0, 9);
      idx = 3'($urandom_range(0, 7));
      a   = ra(int'(idx)) | 16'($urandom_range(0, 1));
      case (r)
        0, 1, 2, 3: begin
          d = 16'($urandom);
          if (idx == 3'd4) d = 16'($urandom_range(0, 5));
          wr_reg(a, d);
        end
        4, 5: rd_reg(a, d);
        6: begin
          ADDR = a; WDATA = 16'($urandom); WE = 1'b1; RE = 1'b1;
          tick();
          WE = 1'b0; RE = 1'b0;
        end
        7: rd_reg(16'($urandom), d);
        8: begin
          KEY = 4'($urandom); SW = 10'($urandom);
          tick();
        end
        default: tick();
      endcase
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
